// File: rtl/clint_ctrl_pkg.sv
// Shared definitions for the core-local interrupt controller: CSR addresses,
// SYSTEM instruction encodings, synchronous cause codes, the sequencer state
// type and the mstatus bit-shuffle helpers used on trap entry and MRET.
package clint_ctrl_pkg;

    // Machine-mode CSR addresses written through the csr_reg side-port
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    // SYSTEM instruction encodings recognised in the execute stage
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    // Synchronous exception cause codes
    localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;
    localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;

    // mstatus bit positions
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEPC,
        ST_MSTATUS,
        ST_MCAUSE,
        ST_MRET_MSTATUS,
        ST_ASSERT
    } state_e;

    // Trap entry: MPIE takes the old MIE, MIE is cleared
    function automatic logic [31:0] trap_mstatus(input logic [31:0] mstatus);
        logic [31:0] r;
        r               = mstatus;
        r[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        return r;
    endfunction

    // MRET: MIE is restored from MPIE, MPIE is set
    function automatic logic [31:0] mret_mstatus(input logic [31:0] mstatus);
        logic [31:0] r;
        r               = mstatus;
        r[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        return r;
    endfunction

    // Zero-extend a 12-bit CSR address onto the 32-bit side-port bus
    function automatic logic [31:0] csr_addr(input logic [11:0] a);
        return {20'h0, a};
    endfunction

endpackage

// File: rtl/clint_ctrl.sv
// Core-local interrupt controller. Detects ECALL/EBREAK/MRET in execute and
// level-sensitive external interrupts, holds the pipeline, writes
// mepc/mstatus/mcause through the csr_reg side-port in a fixed order and then
// issues a one-cycle PC redirect to mtvec (trap) or mepc (MRET).
module clint_ctrl
    import clint_ctrl_pkg::*;
#(
    parameter int          INT_W       = 8,
    parameter logic [31:0] ASYNC_CAUSE = 32'h8000_0007
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_i,
    input  logic [31:0]      inst_addr_i,
    input  logic             jump_flag_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             hold_flag_i,
    input  logic [INT_W-1:0] int_flag_i,
    input  logic [31:0]      csr_mtvec_i,
    input  logic [31:0]      csr_mepc_i,
    input  logic [31:0]      csr_mstatus_i,
    input  logic             global_int_en_i,
    output logic             we_o,
    output logic [31:0]      waddr_o,
    output logic [31:0]      raddr_o,
    output logic [31:0]      data_o,
    output logic             hold_flag_o,
    output logic             int_assert_o,
    output logic [31:0]      int_addr_o
);

    state_e      state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic        we_q, we_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] data_q, data_d;
    logic        int_assert_q, int_assert_d;
    logic [31:0] int_addr_q, int_addr_d;

    logic        detect_en;
    logic        ecall_det, ebreak_det, mret_det, async_det, trap_det;
    logic [31:0] new_cause, new_epc;

    // Events are only accepted while idle and while nothing else holds EX
    assign detect_en  = (state_q == ST_IDLE) && !hold_flag_i;
    assign ecall_det  = detect_en && (inst_i == INST_ECALL);
    assign ebreak_det = detect_en && (inst_i == INST_EBREAK);
    assign mret_det   = detect_en && (inst_i == INST_MRET);
    assign async_det  = detect_en && (|int_flag_i) && global_int_en_i;
    assign trap_det   = ecall_det || ebreak_det || (async_det && !mret_det);

    // Hold must rise in the detect cycle itself so EX cannot retire a CSR write
    assign hold_flag_o = trap_det || mret_det || (state_q != ST_IDLE);

    assign raddr_o      = 32'h0;
    assign we_o         = we_q;
    assign waddr_o      = waddr_q;
    assign data_o       = data_q;
    assign int_assert_o = int_assert_q;
    assign int_addr_o   = int_addr_q;

    // Cause/epc selection in priority order: ECALL, EBREAK, then async
    always_comb begin
        new_cause = ASYNC_CAUSE;
        new_epc   = jump_flag_i ? jump_addr_i : inst_addr_i;
        if (ecall_det) begin
            new_cause = CAUSE_ECALL_M;
            new_epc   = inst_addr_i;
        end else if (ebreak_det) begin
            new_cause = CAUSE_BREAKPOINT;
            new_epc   = inst_addr_i;
        end
    end

    // Next-state and next-output logic for the CSR write sequencer
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned, which would infer a latch.
        state_d      = state_q;
        cause_d      = cause_q;
        epc_d        = epc_q;
        we_d         = 1'b0;
        waddr_d      = 32'h0;
        data_d       = 32'h0;
        int_assert_d = 1'b0;
        int_addr_d   = 32'h0;
        unique case (state_q)
            ST_IDLE: begin
                if (trap_det) begin
                    state_d = ST_MEPC;
                    cause_d = new_cause;
                    epc_d   = new_epc;
                    we_d    = 1'b1;
                    waddr_d = csr_addr(CSR_MEPC);
                    data_d  = new_epc;
                end else if (mret_det) begin
                    state_d = ST_MRET_MSTATUS;
                    we_d    = 1'b1;
                    waddr_d = csr_addr(CSR_MSTATUS);
                    data_d  = mret_mstatus(csr_mstatus_i);
                end
            end
            ST_MEPC: begin
                state_d = ST_MSTATUS;
                we_d    = 1'b1;
                waddr_d = csr_addr(CSR_MSTATUS);
                data_d  = trap_mstatus(csr_mstatus_i);
            end
            ST_MSTATUS: begin
                state_d = ST_MCAUSE;
                we_d    = 1'b1;
                waddr_d = csr_addr(CSR_MCAUSE);
                data_d  = cause_q;
            end
            ST_MCAUSE: begin
                state_d      = ST_ASSERT;
                int_assert_d = 1'b1;
                int_addr_d   = csr_mtvec_i;
            end
            ST_MRET_MSTATUS: begin
                state_d      = ST_ASSERT;
                int_assert_d = 1'b1;
                int_addr_d   = csr_mepc_i;
            end
            ST_ASSERT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered side-port outputs, synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= ST_IDLE;
            cause_q      <= 32'h0;
            epc_q        <= 32'h0;
            we_q         <= 1'b0;
            waddr_q      <= 32'h0;
            data_q       <= 32'h0;
            int_assert_q <= 1'b0;
            int_addr_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            cause_q      <= cause_d;
            epc_q        <= epc_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            data_q       <= data_d;
            int_assert_q <= int_assert_d;
            int_addr_q   <= int_addr_d;
        end
    end

endmodule

// File: tb/tb_clint_ctrl.sv
// Self-checking bench for clint_ctrl: a table of single-event vectors whose
// per-cycle expectations are pushed to a scoreboard queue and popped as the
// DUT steps, plus hand-written sequences for MIE toggling, back-to-back
// ECALL/interrupt and reset in the middle of a trap.
module tb_clint_ctrl;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] ACAUSE = 32'h8000_0007;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i, inst_addr_i, jump_addr_i;
    logic        jump_flag_i, hold_flag_i, global_int_en_i;
    logic [7:0]  int_flag_i;
    logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic        we_o, hold_flag_o, int_assert_o;
    logic [31:0] waddr_o, raddr_o, data_o, int_addr_o;

    clint_ctrl #(.INT_W(8), .ASYNC_CAUSE(32'h8000_0007)) dut (
        .clk             (clk),
        .rst             (rst),
        .inst_i          (inst_i),
        .inst_addr_i     (inst_addr_i),
        .jump_flag_i     (jump_flag_i),
        .jump_addr_i     (jump_addr_i),
        .hold_flag_i     (hold_flag_i),
        .int_flag_i      (int_flag_i),
        .csr_mtvec_i     (csr_mtvec_i),
        .csr_mepc_i      (csr_mepc_i),
        .csr_mstatus_i   (csr_mstatus_i),
        .global_int_en_i (global_int_en_i),
        .we_o            (we_o),
        .waddr_o         (waddr_o),
        .raddr_o         (raddr_o),
        .data_o          (data_o),
        .hold_flag_o     (hold_flag_o),
        .int_assert_o    (int_assert_o),
        .int_addr_o      (int_addr_o)
    );

    always #5 clk = ~clk;

    typedef enum int {K_NONE, K_TRAP, K_MRET} kind_e;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] inst_addr;
        logic        jump_flag;
        logic [31:0] jump_addr;
        logic        hold_in;
        logic [7:0]  int_flag;
        logic        mie;
        logic [31:0] mstatus;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        kind_e       kind;
        logic [31:0] exp_epc;
        logic [31:0] exp_cause;
        logic [31:0] exp_mstatus;
        logic [31:0] exp_target;
    } vec_t;

    typedef struct {
        string       tag;
        logic        we;
        logic [31:0] waddr;
        logic [31:0] data;
        logic        hold;
        logic        ia;
        logic [31:0] iaddr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input string tag, input logic we, input logic [31:0] waddr,
                                    input logic [31:0] data, input logic hold,
                                    input logic ia, input logic [31:0] iaddr);
        exp_t e;
        e.tag = tag; e.we = we; e.waddr = waddr; e.data = data;
        e.hold = hold; e.ia = ia; e.iaddr = iaddr;
        return e;
    endfunction

    task automatic push_idle(input string tag);
        sb.push_back(mk_exp({tag, ".idle"}, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
    endtask

    task automatic push_trap(input string tag, input logic [31:0] epc, input logic [31:0] cause,
                             input logic [31:0] ms, input logic [31:0] tvec, input logic last_hold);
        sb.push_back(mk_exp({tag, ".c1"}, 1'b1, 32'h341, epc,   1'b1, 1'b0, 32'h0));
        sb.push_back(mk_exp({tag, ".c2"}, 1'b1, 32'h300, ms,    1'b1, 1'b0, 32'h0));
        sb.push_back(mk_exp({tag, ".c3"}, 1'b1, 32'h342, cause, 1'b1, 1'b0, 32'h0));
        sb.push_back(mk_exp({tag, ".c4"}, 1'b0, 32'h0,   32'h0, 1'b1, 1'b1, tvec));
        sb.push_back(mk_exp({tag, ".c5"}, 1'b0, 32'h0,   32'h0, last_hold, 1'b0, 32'h0));
    endtask

    task automatic push_mret(input string tag, input logic [31:0] ms, input logic [31:0] mepc);
        sb.push_back(mk_exp({tag, ".c1"}, 1'b1, 32'h300, ms,    1'b1, 1'b0, 32'h0));
        sb.push_back(mk_exp({tag, ".c2"}, 1'b0, 32'h0,   32'h0, 1'b1, 1'b1, mepc));
        sb.push_back(mk_exp({tag, ".c3"}, 1'b0, 32'h0,   32'h0, 1'b0, 1'b0, 32'h0));
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".we"},         {31'h0, we_o},         {31'h0, e.we});
        check({e.tag, ".waddr"},      waddr_o,               e.waddr);
        check({e.tag, ".data"},       data_o,                e.data);
        check({e.tag, ".hold"},       {31'h0, hold_flag_o},  {31'h0, e.hold});
        check({e.tag, ".int_assert"}, {31'h0, int_assert_o}, {31'h0, e.ia});
        check({e.tag, ".int_addr"},   int_addr_o,            e.iaddr);
        check({e.tag, ".raddr"},      raddr_o,               32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        inst_i      = NOP;
        int_flag_i  = 8'h00;
        jump_flag_i = 1'b0;
        hold_flag_i = 1'b0;
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            tick();
            check_out();
        end
    endtask

    // One table entry: drive at negedge, check c0 hold, queue the sequence, step it out
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        inst_i          = v.inst;
        inst_addr_i     = v.inst_addr;
        jump_flag_i     = v.jump_flag;
        jump_addr_i     = v.jump_addr;
        hold_flag_i     = v.hold_in;
        int_flag_i      = v.int_flag;
        global_int_en_i = v.mie;
        csr_mstatus_i   = v.mstatus;
        csr_mtvec_i     = v.mtvec;
        csr_mepc_i      = v.mepc;
        #1;
        check({v.name, ".c0.hold"}, {31'h0, hold_flag_o}, {31'h0, v.kind != K_NONE});
        case (v.kind)
            K_TRAP:  push_trap(v.name, v.exp_epc, v.exp_cause, v.exp_mstatus, v.exp_target, 1'b0);
            K_MRET:  push_mret(v.name, v.exp_mstatus, v.exp_target);
            default: push_idle(v.name);
        endcase
        @(posedge clk);
        #1;
        quiet_inputs();
        #1;
        check_out();
        drain();
    endtask

    function automatic vec_t mk_vec(input string name, input logic [31:0] inst, input logic [31:0] ia,
                                    input logic jf, input logic [31:0] ja, input logic hin,
                                    input logic [7:0] irq, input logic mie, input logic [31:0] ms,
                                    input logic [31:0] tvec, input logic [31:0] mepc, input kind_e kind,
                                    input logic [31:0] eepc, input logic [31:0] ecause,
                                    input logic [31:0] ems, input logic [31:0] etgt);
        vec_t v;
        v.name = name; v.inst = inst; v.inst_addr = ia; v.jump_flag = jf; v.jump_addr = ja;
        v.hold_in = hin; v.int_flag = irq; v.mie = mie; v.mstatus = ms; v.mtvec = tvec;
        v.mepc = mepc; v.kind = kind; v.exp_epc = eepc; v.exp_cause = ecause;
        v.exp_mstatus = ems; v.exp_target = etgt;
        return v;
    endfunction

    vec_t vecs[10];

    initial begin
        vecs[0] = mk_vec("ecall",      ECALL,  32'h100, 1'b0, 32'h0,   1'b0, 8'h00, 1'b1, 32'h8,    32'h200,  32'h0,    K_TRAP, 32'h100, 32'd11, 32'h80,   32'h200);
        vecs[1] = mk_vec("ebreak",     EBREAK, 32'h180, 1'b0, 32'h0,   1'b0, 8'h00, 1'b0, 32'h0,    32'h400,  32'h0,    K_TRAP, 32'h180, 32'd3,  32'h0,    32'h400);
        vecs[2] = mk_vec("irq_jump",   NOP,    32'h33c, 1'b1, 32'h340, 1'b0, 8'h01, 1'b1, 32'h8,    32'h200,  32'h0,    K_TRAP, 32'h340, ACAUSE, 32'h80,   32'h200);
        vecs[3] = mk_vec("irq_nojump", NOP,    32'h500, 1'b0, 32'h777, 1'b0, 8'h80, 1'b1, 32'h1888, 32'h800,  32'h0,    K_TRAP, 32'h500, ACAUSE, 32'h1880, 32'h800);
        vecs[4] = mk_vec("irq_mie0",   NOP,    32'h520, 1'b0, 32'h0,   1'b0, 8'h01, 1'b0, 32'h0,    32'h200,  32'h0,    K_NONE, 32'h0,   32'h0,  32'h0,    32'h0);
        vecs[5] = mk_vec("mret",       MRET,   32'h600, 1'b0, 32'h0,   1'b0, 8'h00, 1'b0, 32'h80,   32'h200,  32'h104,  K_MRET, 32'h0,   32'h0,  32'h88,   32'h104);
        vecs[6] = mk_vec("mret_mpie0", MRET,   32'h640, 1'b0, 32'h0,   1'b0, 8'h00, 1'b1, 32'h08,   32'h200,  32'h2000, K_MRET, 32'h0,   32'h0,  32'h80,   32'h2000);
        vecs[7] = mk_vec("ecall_irq",  ECALL,  32'h700, 1'b1, 32'h999, 1'b0, 8'hff, 1'b1, 32'h8,    32'h300,  32'h0,    K_TRAP, 32'h700, 32'd11, 32'h80,   32'h300);
        vecs[8] = mk_vec("ecall_held", ECALL,  32'h740, 1'b0, 32'h0,   1'b1, 8'h01, 1'b1, 32'h8,    32'h300,  32'h0,    K_NONE, 32'h0,   32'h0,  32'h0,    32'h0);
        vecs[9] = mk_vec("nop",        NOP,    32'h760, 1'b0, 32'h0,   1'b0, 8'h00, 1'b1, 32'h8,    32'h300,  32'h0,    K_NONE, 32'h0,   32'h0,  32'h0,    32'h0);

        rst             = 1'b1;
        inst_addr_i     = 32'h0;
        jump_addr_i     = 32'h0;
        global_int_en_i = 1'b0;
        csr_mtvec_i     = 32'h0;
        csr_mepc_i      = 32'h0;
        csr_mstatus_i   = 32'h0;
        quiet_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset.we",         {31'h0, we_o},         32'h0);
        check("reset.waddr",      waddr_o,               32'h0);
        check("reset.data",       data_o,                32'h0);
        check("reset.int_assert", {31'h0, int_assert_o}, 32'h0);
        check("reset.int_addr",   int_addr_o,            32'h0);
        check("reset.hold",       {31'h0, hold_flag_o},  32'h0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // MIE off: request ignored; MIE on: trap starts in the same cycle
        @(negedge clk);
        inst_addr_i = 32'h900; csr_mstatus_i = 32'h0; csr_mtvec_i = 32'h1000;
        int_flag_i = 8'h01; global_int_en_i = 1'b0;
        #1;
        check("mie_toggle.off.hold", {31'h0, hold_flag_o}, 32'h0);
        push_idle("mie_toggle.off");
        tick();
        check_out();
        global_int_en_i = 1'b1;
        #1;
        check("mie_toggle.on.hold", {31'h0, hold_flag_o}, 32'h1);
        push_trap("mie_toggle", 32'h900, ACAUSE, 32'h0, 32'h1000, 1'b0);
        tick();
        int_flag_i = 8'h00;
        #1;
        check_out();
        drain();

        // ECALL wins over a simultaneous interrupt; the still-pending level is taken next
        @(negedge clk);
        inst_i = ECALL; inst_addr_i = 32'hA00; int_flag_i = 8'h02; global_int_en_i = 1'b1;
        csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h2000;
        #1;
        check("b2b.c0.hold", {31'h0, hold_flag_o}, 32'h1);
        push_trap("b2b.ecall", 32'hA00, 32'd11, 32'h80, 32'h2000, 1'b1);
        tick();
        inst_i = NOP; inst_addr_i = 32'hA04;
        #1;
        for (int c = 0; c < 5; c++) begin
            check_out();
            if (c < 4) tick();
        end
        push_trap("b2b.irq", 32'hA04, ACAUSE, 32'h80, 32'h2000, 1'b0);
        tick();
        int_flag_i = 8'h00;
        #1;
        check_out();
        drain();

        // Reset during c2 of a trap abandons the sequence
        @(negedge clk);
        inst_i = ECALL; inst_addr_i = 32'hB00; csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h3000;
        tick();
        quiet_inputs();
        #1;
        check("rst_mid.c1.waddr", waddr_o, 32'h341);
        tick();
        check("rst_mid.c2.waddr", waddr_o, 32'h300);
        check("rst_mid.c2.we",    {31'h0, we_o}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_mid.we",         {31'h0, we_o},         32'h0);
        check("rst_mid.waddr",      waddr_o,               32'h0);
        check("rst_mid.data",       data_o,                32'h0);
        check("rst_mid.int_assert", {31'h0, int_assert_o}, 32'h0);
        check("rst_mid.int_addr",   int_addr_o,            32'h0);
        check("rst_mid.hold",       {31'h0, hold_flag_o},  32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_mid.after.we",         {31'h0, we_o},         32'h0);
            check("rst_mid.after.int_assert", {31'h0, int_assert_o}, 32'h0);
            check("rst_mid.after.hold",       {31'h0, hold_flag_o},  32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish within bound");
        $fatal(1, "timeout");
    end

endmodule
